// File: rtl/modn_counter_if.sv
// rtl/modn_counter_if.sv - control/status bundle for modn_counter
interface modn_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             one_shot;
  logic             term_wr;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] term_q;
  logic             tc;
  logic             wrap;
  logic             done;

  modport master (
    output en, up, clr, load, load_val, one_shot, term_wr, term_val,
    input  count, term_q, tc, wrap, done
  );

  modport slave (
    input  en, up, clr, load, load_val, one_shot, term_wr, term_val,
    output count, term_q, tc, wrap, done
  );
endinterface

// File: rtl/modn_counter.sv
// rtl/modn_counter.sv - up/down modulo-N counter with programmable terminal, load, clear and one-shot
module modn_counter #(
  parameter int WIDTH       = 3,
  parameter int DEFAULT_MOD = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  modn_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] TERM_RST = WIDTH'(DEFAULT_MOD - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] term_r;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap_q;
  logic             wrap_d;
  logic             done_q;
  logic             done_d;
  logic             at_term;
  logic             step;

  // >= in up mode lets the count recover after term_q is lowered below it
  assign at_term      = bus.up ? (count_q >= term_r) : (count_q == '0);
  assign step         = bus.en & ~done_q;
  assign load_clamped = (bus.load_val > term_r) ? term_r : bus.load_val;

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (bus.load) begin
      count_d = load_clamped;
      done_d  = 1'b0;
    end else if (step) begin
      if (!at_term) begin
        count_d = bus.up ? count_q + 1'b1 : count_q - 1'b1;
      end else if (!bus.one_shot) begin
        count_d = bus.up ? '0 : term_r;
        wrap_d  = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      term_r  <= TERM_RST;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      if (bus.term_wr) begin
        term_r <= bus.term_val;
      end
    end
  end

  assign bus.count  = count_q;
  assign bus.term_q = term_r;
  assign bus.wrap   = wrap_q;
  assign bus.done   = done_q;
  assign bus.tc     = step & ~bus.clr & ~bus.load & at_term;
endmodule

// File: doc/modn_counter.md
# modn_counter

Parametrised modulo-N counter that generalises the fixed mod-6 counter in the timer/sequencer area. It counts up or down between 0 and a run-time programmable terminal value. It supports enable, synchronous clear, parallel load, and wrap or one-shot (halt) modes. It provides a combinational terminal-count output for cascading and registered wrap/done status for software-visible sequencing.

## Interface
Parameters:
- WIDTH, 3, counter/terminal width in bits (≥1)
- DEFAULT_MOD, 6, modulus after reset (terminal = DEFAULT_MOD-1); must satisfy 1 ≤ DEFAULT_MOD ≤ 2**WIDTH

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  count enable
- up  in  1  direction: 1 = up, 0 = down
- clr  in  1  synchronous clear
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value for load
- one_shot  in  1  1 = halt at terminal, 0 = wrap
- term_wr  in  1  write new terminal value
- term_val  in  WIDTH  new terminal value (modulus-1)
- count  out  WIDTH  current count (registered)
- term_q  out  WIDTH  active terminal value (registered)
- tc  out  1  terminal count, combinational
- wrap  out  1  one-cycle pulse, registered
- done  out  1  sticky one-shot completion flag, registered

## Operation
- Reset (rst_n=0, async):
  - count=0
  - term_q=DEFAULT_MOD-1
  - wrap=0
  - done=0
- at_term:
  - up=1: count ≥ term_q (≥ so that a lowered term_q recovers).
  - up=0: count == 0.
- Per-cycle count priority:
  1. clr: count←0, done←0.
  2. load: count←min(load_val, term_q), done←0.
  3. en & ~done & ~at_term: up → count+1; down → count-1.
  4. en & ~done & at_term & one_shot=0: wrap. Up → 0; down → term_q. wrap←1 next cycle.
  5. en & ~done & at_term & one_shot=1: count holds, done←1. No wrap pulse.
  6. Otherwise: hold.
- While done=1, en has no effect. done is cleared only by clr or load.
- term_wr: term_q←term_val, independent of the count priority chain. The count decision in the same cycle uses the old term_q.
- tc = en & ~done & ~clr & ~load & at_term. Used as the enable for a cascaded higher digit.
- wrap is 1 for exactly the cycle after a wrap step, otherwise 0.
- term_q=0 (mod-1): up mode holds 0 and wraps every enabled cycle (wrap pulses continuously). Down mode behaves the same.
- Direction change mid-count takes effect on the next enabled step. No state is reset.
- All arithmetic is modulo 2**WIDTH internally. Overflow cannot occur because every step is bounded by term_q.

## Timing
- count, term_q, wrap, done update on the rising clk edge. Latency from input to output is 1 cycle.
- tc is combinational from registered state plus en/clr/load. There is no flop on it.
- Reset assertion is asynchronous. Deassertion must be synchronised externally. First count step occurs on the first rising edge with rst_n=1 and en=1.
- Reset mid-count forces all outputs to their reset values immediately.

## Test plan
- Reset defaults, WIDTH=3, DEFAULT_MOD=6: en=1, up=1 for 13 cycles → count 0,1,2,3,4,5,0,1,…; tc high while count=5; wrap high on the cycle count shows 0 after 5.
- Down count: up=0 from 0 → count 5,4,3,2,1,0,5; tc high at 0; wrap pulses after each 0→5 step.
- Re-program: term_wr=1, term_val=2 while count=4 → next up step goes to 0 (≥ rule); sequence then 0,1,2,0. Same-cycle term_wr with count=5 under old term=5 → wraps to 0.
- One-shot: one_shot=1, count to 5 → count holds at 5, done=1, no wrap pulse, en ignored; load with load_val=7 → count=5 (clamped), done=0.
- Priority: clr=1 and load=1 with en=1 → count=0; load=1 with en=1 and load_val=3 → count=3; tc=0 in both cycles.
- Async reset mid-count at count=4 → count=0, term_q=5, wrap=0, done=0 before the next clk edge.
